// File: rtl/mem_bus_controller.sv
// Memory-side load/store stage between the CPU core and a word-wide synchronous SRAM.
// Handles byte lanes, zero-extended byte loads, wait states and illegal-access rejection.
module mem_bus_controller #(
  parameter int MEM_WORDS   = 1024,
  parameter int AW          = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_write,
  input  logic          cpu_byte,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  output logic          cpu_error,
  output logic          sram_en,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  logic [1:0]    state_q, state_d;
  logic          write_q, write_d;
  logic          byte_q, byte_d;
  logic          err_q, err_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          illegal;
  logic [3:0]    laneBe;
  logic [7:0]    laneByte;

  always_comb begin
    illegal = (!cpu_byte && (cpu_addr[1:0] != 2'b00)) || ({1'b0, cpu_addr} >= ADDR_LIMIT);
  end

  always_comb begin
    laneBe = 4'b0001 << addr_q[1:0];
    case (addr_q[1:0])
      2'd0:    laneByte = sram_rdata[7:0];
      2'd1:    laneByte = sram_rdata[15:8];
      2'd2:    laneByte = sram_rdata[23:16];
      default: laneByte = sram_rdata[31:24];
    endcase
  end

  // Request fields are only captured in IDLE, so the core may change them freely afterwards.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    byte_d  = byte_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          write_d = cpu_write;
          byte_d  = cpu_byte;
          addr_d  = cpu_addr[AW+1:0];
          wdata_d = cpu_wdata;
          err_d   = illegal;
          state_d = illegal ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d   = 4'(WAIT_STATES);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Counter saturates at zero; the final WAIT cycle is the one that sees zero.
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!write_q) begin
            rdata_d = byte_q ? {24'h0, laneByte} : sram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  assign sram_en    = (state_q == S_ACCESS);
  assign sram_we    = sram_en & write_q;
  assign sram_be    = sram_en ? (byte_q ? laneBe : 4'hF) : 4'h0;
  assign sram_addr  = addr_q[AW+1:2];
  assign sram_wdata = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_ready  = (state_q == S_DONE);
  assign cpu_error  = (state_q == S_DONE) & err_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Scoreboard bench for mem_bus_controller: a reference memory predicts each result,
// expectations are queued at issue time and popped when the controller signals ready.
module tb_mem_bus_controller;

  localparam int MEM_WORDS = 1024;
  localparam int AW        = 10;
  localparam int WS        = 1;

  typedef struct {
    logic          err;
    logic [31:0]   rdata;
    int            lat;
    int            enCount;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic          cpu_write;
  logic          cpu_byte;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          cpu_error;
  logic          sram_en;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  bit   [31:0]   sram_rdata;

  bit   [31:0]   sramMem [MEM_WORDS];
  bit   [31:0]   refMem  [MEM_WORDS];
  logic [31:0]   lastRdata;
  exp_t          expQ [$];
  int            nCompared   = 0;
  int            nMismatched = 0;

  mem_bus_controller #(
    .MEM_WORDS  (MEM_WORDS),
    .AW         (AW),
    .WAIT_STATES(WS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_write (cpu_write),
    .cpu_byte  (cpu_byte),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_error (cpu_error),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_be   (sram_be),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears after the enable edge and holds until the next read.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int i = 0; i < 4; i++) begin
          if (sram_be[i]) sramMem[sram_addr][i*8 +: 8] <= sram_wdata[i*8 +: 8];
        end
      end else begin
        sram_rdata <= sramMem[sram_addr];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Predicts the outcome of one request, queues it, and drives the request onto the bus.
  task automatic applyStimulus(input logic w, input logic b, input logic [31:0] a,
                               input logic [31:0] d, input bit backToBack);
    exp_t e;
    logic ill;
    int   wi;
    int   lane;
    if (!backToBack) @(negedge clk);
    ill  = (!b && (a[1:0] != 2'b00)) || (a >= 32'(MEM_WORDS * 4));
    wi   = int'(a[AW+1:2]);
    lane = int'(a[1:0]);
    if (!ill) begin
      if (w) begin
        if (b) refMem[wi][lane*8 +: 8] = d[7:0];
        else   refMem[wi] = d;
      end else begin
        lastRdata = b ? {24'h0, refMem[wi][lane*8 +: 8]} : refMem[wi];
      end
    end
    e.err     = ill;
    e.rdata   = lastRdata;
    e.lat     = (ill ? 1 : 3 + WS) + (backToBack ? 1 : 0);
    e.enCount = ill ? 0 : 1;
    e.we      = w;
    e.be      = b ? (4'b0001 << a[1:0]) : 4'hF;
    e.addr    = a[AW+1:2];
    e.wdata   = b ? {4{d[7:0]}} : d;
    expQ.push_back(e);
    cpu_req   = 1'b1;
    cpu_write = w;
    cpu_byte  = b;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  // Watches the bus until ready (bounded), then pops the oldest expectation and compares.
  task automatic collectResult(input bit holdNext);
    exp_t          e;
    int            k       = 0;
    int            enSeen  = 0;
    int            badIdle = 0;
    bit            seen    = 1'b0;
    logic          weS     = 1'b0;
    logic [3:0]    beS     = 4'h0;
    logic [AW-1:0] addrS   = '0;
    logic [31:0]   wdS     = 32'h0;
    while (!seen && k < 50) begin
      @(negedge clk);
      k++;
      if (sram_en) begin
        enSeen++;
        weS   = sram_we;
        beS   = sram_be;
        addrS = sram_addr;
        wdS   = sram_wdata;
      end else if (sram_we || (sram_be != 4'h0)) begin
        badIdle++;
      end
      if (cpu_ready) seen = 1'b1;
    end
    e = expQ.pop_front();
    checkOutput("latency", 32'(k), 32'(e.lat));
    checkOutput("error", 32'(cpu_error), 32'(e.err));
    checkOutput("rdata", cpu_rdata, e.rdata);
    checkOutput("enCount", 32'(enSeen), 32'(e.enCount));
    checkOutput("idleStrobes", 32'(badIdle), 32'd0);
    if (e.enCount != 0) begin
      checkOutput("sramWe", 32'(weS), 32'(e.we));
      checkOutput("sramBe", 32'(beS), 32'(e.be));
      checkOutput("sramAddr", 32'(addrS), 32'(e.addr));
      checkOutput("sramWdata", wdS, e.wdata);
    end
    if (!holdNext) cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    logic        rw;
    logic        rb;
    rst       = 1'b0;
    cpu_req   = 1'b0;
    cpu_write = 1'b0;
    cpu_byte  = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    lastRdata = 32'h0;

    // Request pending during reset must be ignored, then accepted on the first edge after release.
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstRdata", cpu_rdata, 32'h0);
      checkOutput("rstCtl", {24'h0, cpu_ready, cpu_error, sram_en, sram_we, sram_be}, 32'h0);
      checkOutput("rstAddr", 32'(sram_addr), 32'h0);
      checkOutput("rstWdata", sram_wdata, 32'h0);
    end
    rst = 1'b1;
    collectResult(1'b0);

    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
    collectResult(1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    collectResult(1'b0);

    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h1122_3344, 1'b0);
    collectResult(1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0043, 32'h0000_00A5, 1'b0);
    collectResult(1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    collectResult(1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0042, 32'h0, 1'b0);
    collectResult(1'b0);

    applyStimulus(1'b0, 1'b0, 32'h0000_0006, 32'h0, 1'b0);
    collectResult(1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0000_1000, 32'h0, 1'b0);
    collectResult(1'b0);
    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0077, 1'b0);
    collectResult(1'b0);

    applyStimulus(1'b1, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0);
    collectResult(1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0FFF, 32'h0, 1'b0);
    collectResult(1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0FFC, 32'h0, 1'b0);
    collectResult(1'b0);

    // Held request: each new request is accepted in the IDLE cycle right after DONE.
    applyStimulus(1'b1, 1'b0, 32'h0000_0080, 32'h89AB_CDEF, 1'b0);
    collectResult(1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0000_0080, 32'h0, 1'b1);
    collectResult(1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0081, 32'h0, 1'b1);
    collectResult(1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0000_0082, 32'h0, 1'b1);
    collectResult(1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0082, 32'h0000_005A, 1'b1);
    collectResult(1'b0);

    // Reset during ACCESS abandons the load without a ready pulse.
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_write = 1'b0;
    cpu_byte  = 1'b0;
    cpu_addr  = 32'h0000_0040;
    @(negedge clk);
    checkOutput("midEnBefore", 32'(sram_en), 32'd1);
    #1 rst = 1'b0;
    #1 checkOutput("midEnAfter", 32'(sram_en), 32'd0);
    cpu_req   = 1'b0;
    lastRdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("midNoReady", 32'(cpu_ready), 32'd0);
    end
    checkOutput("midRdata", cpu_rdata, 32'h0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0000_0080, 32'h0, 1'b0);
    collectResult(1'b0);

    for (int i = 0; i < 12; i++) begin
      rw = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      ra = 32'($urandom_range(0, 63)) << 2;
      if (rb) ra[1:0] = 2'($urandom_range(0, 3));
      rd = $urandom;
      applyStimulus(rw, rb, ra, rd, 1'b0);
      collectResult(1'b0);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
